// File: rtl/phys_free_list_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : phys_free_list_if                                           |
// | Description: Rename/commit side bundle for the physical tag free list.   |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
interface phys_free_list_if #(
   parameter int PHYS_W = 6,
   parameter int CNT_W  = 6
);
   logic              alloc_req;
   logic              alloc_gnt;
   logic [PHYS_W-1:0] alloc_phys;
   logic              retire_valid;
   logic [PHYS_W-1:0] retire_phys_old;
   logic              flush;
   logic [CNT_W-1:0]  free_count;
   logic              empty;
   logic              err_overflow;

   modport master (
      output alloc_req, retire_valid, retire_phys_old, flush,
      input  alloc_gnt, alloc_phys, free_count, empty, err_overflow
   );

   modport slave (
      input  alloc_req, retire_valid, retire_phys_old, flush,
      output alloc_gnt, alloc_phys, free_count, empty, err_overflow
   );
endinterface
`default_nettype wire

// File: rtl/phys_free_list.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : phys_free_list                                              |
// | Description: Circular free list of physical register tags with a        |
// |              committed head for single-cycle flush recovery.             |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module phys_free_list #(
   parameter int NUM_ARCH = 32,
   parameter int NUM_PHYS = 64,
   parameter int PHYS_W   = $clog2(NUM_PHYS),
   parameter int DEPTH    = NUM_PHYS - NUM_ARCH
) (
   input  logic              clk,
   input  logic              rst,
   phys_free_list_if.slave   bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PHYS_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  spec_head_q, spec_head_d;
   logic [PTR_W-1:0]  commit_head_q, commit_head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic              err_q, err_d;

   logic [PTR_W-1:0]  w_free_count;
   logic              w_empty;
   logic              w_full;
   logic              w_gnt;
   logic              w_push;
   logic              w_drop;

   assign w_free_count = tail_q - spec_head_q;
   assign w_empty      = (tail_q == spec_head_q);
   assign w_full       = (w_free_count == PTR_W'(DEPTH));
   assign w_gnt        = bus.alloc_req & ~w_empty & ~bus.flush;

   // A full list can still accept a push when a grant frees a slot on the same edge.
   assign w_push = bus.retire_valid & (bus.retire_phys_old != '0) & (~w_full | w_gnt);
   assign w_drop = bus.retire_valid & ~w_push;

   always_comb begin
      spec_head_d   = spec_head_q;
      commit_head_d = commit_head_q;
      tail_d        = tail_q;
      err_d         = err_q;
      if (w_gnt) begin
         spec_head_d = spec_head_q + PTR_W'(1);
      end
      if (bus.retire_valid) begin
         commit_head_d = commit_head_q + PTR_W'(1);
      end
      if (w_push) begin
         tail_d = tail_q + PTR_W'(1);
      end
      // Recovery uses the commit head including this cycle's retirement.
      if (bus.flush) begin
         spec_head_d = commit_head_d;
      end
      if (w_drop) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= PHYS_W'(NUM_ARCH + i);
         end
         spec_head_q   <= '0;
         commit_head_q <= '0;
         tail_q        <= PTR_W'(DEPTH);
         err_q         <= 1'b0;
      end else begin
         if (w_push) begin
            mem_q[tail_q[IDX_W-1:0]] <= bus.retire_phys_old;
         end
         spec_head_q   <= spec_head_d;
         commit_head_q <= commit_head_d;
         tail_q        <= tail_d;
         err_q         <= err_d;
      end
   end

   assign bus.alloc_gnt    = w_gnt;
   assign bus.alloc_phys   = mem_q[spec_head_q[IDX_W-1:0]];
   assign bus.free_count   = w_free_count;
   assign bus.empty        = w_empty;
   assign bus.err_overflow = err_q;
endmodule
`default_nettype wire

// File: tb/tb_phys_free_list.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_phys_free_list                                           |
// | Description: Vector-table bench for the physical tag free list.         |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_phys_free_list;
   typedef struct {
      logic       rst;
      logic       req;
      logic       rv;
      logic [5:0] old;
      logic       fl;
      logic       chk;
      logic       gnt;
      logic [5:0] phys;
      logic [5:0] cnt;
      logic       emp;
      logic       err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   vec_t exp_q[$];

   phys_free_list_if #(.PHYS_W(6), .CNT_W(6)) bus ();

   phys_free_list dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic void add(input logic r, input logic req, input logic rv,
                               input int old, input logic fl, input logic chk,
                               input logic gnt, input int phys, input int cnt,
                               input logic emp, input logic err);
      vec_t v;
      v.rst = r; v.req = req; v.rv = rv; v.old = 6'(old); v.fl = fl;
      v.chk = chk; v.gnt = gnt; v.phys = 6'(phys); v.cnt = 6'(cnt);
      v.emp = emp; v.err = err;
      vecs.push_back(v);
   endfunction

   function automatic void add_rst();
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic check(input string name, input int k, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s vec%0d: got %0d expected %0d", name, k, act, exp);
      end
   endtask

   initial begin
      bus.alloc_req       = 1'b0;
      bus.retire_valid    = 1'b0;
      bus.retire_phys_old = '0;
      bus.flush           = 1'b0;

      // Drain the whole list, then hit empty.
      add_rst();
      add(0, 0, 0, 0, 0, 1, 0, 32, 32, 0, 0);
      for (int i = 0; i < 32; i++) add(0, 1, 0, 0, 0, 1, 1, 32 + i, 32 - i, 0, 0);
      add(0, 1, 0, 0, 0, 1, 0, 32, 0, 1, 0);
      // Retire into an empty list: no bypass, visible next cycle.
      add(0, 1, 1, 5, 0, 1, 0, 32, 0, 1, 0);
      add(0, 0, 0, 0, 0, 1, 0, 5, 1, 0, 0);

      // Three allocs, one retire, flush restores to commit head.
      add_rst();
      add(0, 0, 0, 0, 0, 1, 0, 32, 32, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 1, 1, 32 + i, 32 - i, 0, 0);
      add(0, 0, 1, 7, 0, 1, 0, 35, 29, 0, 0);
      add(0, 1, 0, 0, 1, 1, 0, 35, 30, 0, 0);
      for (int i = 1; i < 32; i++) add(0, 1, 0, 0, 0, 1, 1, 32 + i, 33 - i, 0, 0);
      add(0, 1, 0, 0, 0, 1, 1, 7, 1, 0, 0);
      add(0, 1, 0, 0, 0, 1, 0, 33, 0, 1, 0);

      // Flush in the same cycle as a retire picks up the advanced commit head.
      add_rst();
      add(0, 1, 0, 0, 0, 1, 1, 32, 32, 0, 0);
      add(0, 1, 0, 0, 0, 1, 1, 33, 31, 0, 0);
      add(0, 1, 1, 20, 1, 1, 0, 34, 30, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 33, 32, 0, 0);

      // Simultaneous alloc and retire keep the count steady.
      add_rst();
      for (int i = 0; i < 10; i++) add(0, 1, 1, 9, 0, 1, 1, 32 + i, 32, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 42, 32, 0, 0);

      // Illegal x0 return, then overflow on a full list.
      add_rst();
      add(0, 1, 0, 0, 0, 1, 1, 32, 32, 0, 0);
      add(0, 0, 1, 0, 0, 1, 0, 33, 31, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 33, 31, 0, 1);
      add_rst();
      add(0, 0, 1, 9, 0, 1, 0, 32, 32, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 32, 32, 0, 1);
      add(0, 1, 0, 0, 0, 1, 1, 32, 32, 0, 1);

      // Reset mid-stream with everything asserted.
      add_rst();
      add(0, 1, 0, 0, 0, 1, 1, 32, 32, 0, 0);
      add(0, 1, 1, 0, 0, 1, 1, 33, 31, 0, 0);
      add(0, 1, 1, 11, 0, 1, 1, 34, 30, 0, 1);
      add(1, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 32, 32, 0, 0);
      add(0, 1, 0, 0, 0, 1, 1, 32, 32, 0, 0);

      for (int k = 0; k < vecs.size(); k++) begin
         vec_t e;
         @(negedge clk);
         rst                 = vecs[k].rst;
         bus.alloc_req       = vecs[k].req;
         bus.retire_valid    = vecs[k].rv;
         bus.retire_phys_old = vecs[k].old;
         bus.flush           = vecs[k].fl;
         exp_q.push_back(vecs[k]);
         #1;
         e = exp_q.pop_front();
         if (e.chk) begin
            check("alloc_gnt",    k, int'(bus.alloc_gnt),    int'(e.gnt));
            check("alloc_phys",   k, int'(bus.alloc_phys),   int'(e.phys));
            check("free_count",   k, int'(bus.free_count),   int'(e.cnt));
            check("empty",        k, int'(bus.empty),        int'(e.emp));
            check("err_overflow", k, int'(bus.err_overflow), int'(e.err));
         end
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
